// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline chain.
package pipe_pkg;

    // Width of the occupancy counter: holds 0..depth+1.
    function automatic int unsigned pipe_cnt_w(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data register with load enable, async active-low reset and sync clear.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = in_valid;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipe_chain.sv
// Elastic valid/ready pipeline of DEPTH stages with flush and occupancy count.
// Define PIPE_CHAIN_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [pipe_cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned CNT_W = pipe_cnt_w(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ld;
    logic [WIDTH-1:0] d [DEPTH];
    logic             xfer_in;
    logic             xfer_out;
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic [CNT_W-1:0] count_q, count_d;

    // A stage loads unless it and every stage after it are full and the output is stalled.
    always_comb begin
        logic full_run;
        full_run = 1'b1;
        ld       = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            full_run = full_run & v[i];
            ld[i]    = out_ready || !full_run;
        end
    end

    assign xfer_out = v[DEPTH-1] && out_ready && !clear;

`ifdef PIPE_CHAIN_SKID_EN
    logic             sk_v;
    logic [WIDTH-1:0] sk_d;
    logic             sk_load;
    logic             sk_in_v;
    logic             in_ready_q, in_ready_d;

    assign in_ready = in_ready_q && !clear && reset;
    assign xfer_in  = in_valid && in_ready;
    // Skid only captures what stage 0 cannot take; when holding, it drains first.
    assign sk_load  = !sk_v || ld[0];
    assign sk_in_v  = xfer_in && !ld[0];
    assign src_v    = sk_v || xfer_in;
    assign src_d    = sk_v ? sk_d : in_data;

    pipe_stage #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (sk_load),
        .in_valid  (sk_in_v),
        .in_data   (in_data),
        .out_valid (sk_v),
        .out_data  (sk_d)
    );

    always_comb begin
        in_ready_d = 1'b1;
        if (!clear) begin
            in_ready_d = sk_load ? !sk_in_v : !sk_v;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end
`else
    assign in_ready = !clear && reset && ld[0];
    assign xfer_in  = in_valid && in_ready;
    assign src_v    = xfer_in;
    assign src_d    = in_data;
`endif

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;
        if (i == 0) begin : g_head
            assign pv = src_v;
            assign pd = src_d;
        end else begin : g_body
            assign pv = v[i-1];
            assign pd = d[i-1];
        end
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear),
            .load      (ld[i]),
            .in_valid  (pv),
            .in_data   (pd),
            .out_valid (v[i]),
            .out_data  (d[i])
        );
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (xfer_in && !xfer_out) begin
            count_d = count_q + CNT_W'(1);
        end else if (xfer_out && !xfer_in) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_chain.sv
// Directed self-checking bench for pipe_chain (WIDTH=8, DEPTH=2).
module tb_pipe_chain;

`ifdef PIPE_CHAIN_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    int checks   = 0;
    int failures = 0;

    pipe_chain #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recvd;
        logic fire_in;
        logic fire_out;

        reset     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), SKID ? 32'd0 : 32'd1);
        next_edge();

        // Streaming 0x01..0x08 with out_ready held high
        for (int k = 1; k <= 10; k++) begin
            in_valid  = (k <= 8);
            in_data   = 8'(k);
            out_ready = 1'b1;
            @(negedge clk);
            if (k <= 8) check("t1_in_ready", 32'(in_ready), 32'd1);
            next_edge();
            check("t1_out_valid", 32'(out_valid), (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 9) check("t1_out_data", 32'(out_data), 32'(k - 1));
            check("t1_count", 32'(count), (k == 1 || k == 9) ? 32'd1 : (k == 10 ? 32'd0 : 32'd2));
        end

        // Fill with 0xA0,0xA1 then stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA0;
        next_edge();
        in_data   = 8'hA1;
        next_edge();
        in_valid  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t2_in_ready",  32'(in_ready),  SKID ? 32'd1 : 32'd0);
            check("t2_out_valid", 32'(out_valid), 32'd1);
            check("t2_out_data",  32'(out_data),  32'hA0);
            check("t2_count",     32'(count),     32'd2);
            next_edge();
        end
        out_ready = 1'b1;
        next_edge();
        check("t2_rel_data",  32'(out_data),  32'hA1);
        check("t2_rel_count", 32'(count),     32'd1);
        next_edge();
        check("t2_empty_valid", 32'(out_valid), 32'd0);
        check("t2_empty_count", 32'(count),     32'd0);

        // out_ready toggling with continuous input from 0x10
        sent  = 0;
        recvd = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c % 2 == 0);
            in_valid  = 1'b1;
            in_data   = 8'(8'h10 + sent);
            @(negedge clk);
            check("t3_count", 32'(count), 32'(sent - recvd));
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) check("t3_order", 32'(out_data), 32'(8'h10 + recvd));
            next_edge();
            if (fire_in)  sent++;
            if (fire_out) recvd++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 8 && recvd != sent; n++) begin
            @(negedge clk);
            if (out_valid) begin
                check("t3_drain_order", 32'(out_data), 32'(8'h10 + recvd));
                recvd++;
            end
            next_edge();
        end
        check("t3_all_received", 32'(recvd), 32'(sent));
        check("t3_final_count",  32'(count), 32'd0);

        // Clear while full, input offered and output ready
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h50;
        next_edge();
        in_data   = 8'h51;
        next_edge();
        clear     = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'h52;
        @(negedge clk);
        check("t4_clr_in_ready", 32'(in_ready), 32'd0);
        check("t4_pre_data",     32'(out_data), 32'h50);
        next_edge();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_out_data",  32'(out_data),  32'd0);
        check("t4_count",     32'(count),     32'd0);
        @(negedge clk);
        check("t4_post_in_ready", 32'(in_ready), 32'd1);
        next_edge();
        check("t4_post_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h60;
        next_edge();
        in_data   = 8'h61;
        next_edge();
        check("t5_pre_data",  32'(out_data), 32'h60);
        check("t5_pre_count", 32'(count),    32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_data",  32'(out_data),  32'd0);
        check("t5_count",     32'(count),     32'd0);
        check("t5_in_ready",  32'(in_ready),  32'd0);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        next_edge();
        check("t5_after_valid", 32'(out_valid), 32'd0);
        check("t5_after_count", 32'(count),     32'd0);

`ifdef PIPE_CHAIN_SKID_EN
        // Skid entry absorbs a third word while stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            in_data = 8'(8'h30 + n);
            @(negedge clk);
            check("t6_in_ready", 32'(in_ready), 32'd1);
            next_edge();
        end
        in_valid = 1'b0;
        check("t6_count",    32'(count),    32'd3);
        check("t6_head",     32'(out_data), 32'h30);
        @(negedge clk);
        check("t6_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        next_edge();
        check("t6_d31", 32'(out_data), 32'h31);
        check("t6_c2",  32'(count),    32'd2);
        next_edge();
        check("t6_d32", 32'(out_data), 32'h32);
        check("t6_c1",  32'(count),    32'd1);
        next_edge();
        check("t6_empty", 32'(out_valid), 32'd0);
        check("t6_c0",    32'(count),     32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
